// File: rtl/noc_pkg.sv
// Shared types and field layout for the NoC packet injector.
// Packet layout: [13:11] dest, [10:8] src, [7:0] payload.
package noc_pkg;

  localparam int WIDTH_PACKET  = 14;
  localparam int WIDTH_ADDR    = 3;
  localparam int WIDTH_PAYLOAD = WIDTH_PACKET - 2 * WIDTH_ADDR;

  localparam int DEST_MSB    = WIDTH_PACKET - 1;
  localparam int DEST_LSB    = WIDTH_PACKET - WIDTH_ADDR;
  localparam int SRC_MSB     = DEST_LSB - 1;
  localparam int SRC_LSB     = DEST_LSB - WIDTH_ADDR;
  localparam int PAYLOAD_MSB = SRC_LSB - 1;
  localparam int PAYLOAD_LSB = 0;

  typedef struct packed {
    logic [WIDTH_ADDR-1:0]    dest;
    logic [WIDTH_ADDR-1:0]    src;
    logic [WIDTH_PAYLOAD-1:0] payload;
  } noc_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ_HI,
    REQ_LO
  } inj_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of 2.
// Push is ignored when full and pop is ignored when empty.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Buffers PE requests, packs them with the local node id and drives them into
// a router input using a 4-phase bundled-data req/ack handshake.
module noc_packet_injector
  import noc_pkg::*;
#(
  parameter int                    WIDTH_packet = 14,
  parameter int                    WIDTH_addr   = 3,
  parameter logic [WIDTH_addr-1:0] NODE_ID      = '0,
  parameter int                    FIFO_DEPTH   = 4,
  parameter int                    SETUP_CYC    = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pe_valid,
  output logic                                pe_ready,
  input  logic [WIDTH_addr-1:0]               pe_dest,
  input  logic [WIDTH_packet-2*WIDTH_addr-1:0] pe_payload,
  output logic                                noc_req,
  output logic [WIDTH_packet-1:0]             noc_data,
  input  logic                                noc_ack,
  output logic                                busy,
  output logic [15:0]                         sent_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC);

  logic [1:0]              rst_pipe;
  logic                    rst_int_n;
  logic [1:0]              ack_pipe;
  logic                    ack_s;
  logic                    ready_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [WIDTH_packet-1:0] fifo_rdata;
  logic [WIDTH_packet-1:0] pe_packet;
  logic                    push;
  logic                    pop;
  logic [3:0]              setup_cnt;
  inj_state_e              state;

  // Reset asserts asynchronously but is released only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_int_n = rst_pipe[1];

  // Left unreset so a stale ack held across reset is already visible at release.
  always_ff @(posedge clk) begin
    ack_pipe <= {ack_pipe[0], noc_ack};
  end
  assign ack_s = ack_pipe[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) ready_q <= 1'b0;
    else            ready_q <= 1'b1;
  end

  assign pe_ready  = ready_q & ~fifo_full;
  assign push      = pe_valid & pe_ready;
  assign pe_packet = {pe_dest, NODE_ID, pe_payload};
  assign pop       = (state == IDLE) & ~fifo_empty & ~ack_s;
  assign busy      = (fifo_count != '0) | (state != IDLE);

  noc_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WIDTH_packet)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_int_n),
    .push  (push),
    .wdata (pe_packet),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: all FSM state and registered outputs use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= IDLE;
      noc_req    <= 1'b0;
      noc_data   <= '0;
      setup_cnt  <= '0;
      sent_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            noc_data  <= fifo_rdata;
            setup_cnt <= SETUP_LOAD;
            state     <= SETUP;
          end
        end
        SETUP: begin
          setup_cnt <= setup_cnt - 4'd1;
          if (setup_cnt == 4'd1) begin
            noc_req <= 1'b1;
            state   <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            noc_req <= 1'b0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          // noc_data stays frozen until the return-to-zero phase completes.
          if (!ack_s) begin
            sent_count <= sent_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
